// File: rtl/meas_seq_ctrl.sv
// Sequences measure/Rr/Vr selection for the analog shifter, waits for settling, acquires Vx then Vr,
// and optionally steps the reference resistor until the Vr amplitude lands inside [RANGE_LO, RANGE_HI].
module meas_seq_ctrl #(
   parameter int               SETTLE_CYCLES = 200000,
   parameter int               AMP_W         = 16,
   parameter logic [AMP_W-1:0] RANGE_LO      = 16'd4096,
   parameter logic [AMP_W-1:0] RANGE_HI      = 16'd52000,
   parameter int               MAX_STEPS     = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic             i_auto_range,
   input  logic [2:0]       i_Rr_init,
   input  logic [1:0]       i_Vr_Sel,
   input  logic             i_acq_done,
   input  logic [AMP_W-1:0] i_acq_amp,
   output logic [3:0]       o_CTRL_Measure_Sel,
   output logic [2:0]       o_CTRL_Rr_Sel,
   output logic [1:0]       o_CTRL_Vr_Sel,
   output logic             o_acq_req,
   output logic [AMP_W-1:0] o_amp_vx,
   output logic [AMP_W-1:0] o_amp_vr,
   output logic [2:0]       o_range,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_range_err
);

   localparam int                CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam int                STEP_W   = $clog2(MAX_STEPS + 1);
   localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

   localparam logic [3:0] MSEL_VX  = 4'd0;
   localparam logic [3:0] MSEL_VR  = 4'd1;
   localparam logic [3:0] MSEL_GND = 4'd6;

   typedef enum logic [2:0] {
      S_IDLE, S_APPLY, S_SETTLE, S_REQ, S_WAIT, S_CHECK, S_DONE
   } state_t;

   // Ranks are ordered by increasing Rr; codes are what the shifter expects.
   function automatic logic [2:0] rank_to_code(input logic [2:0] rank);
      case (rank)
         3'd0:    return 3'd3;
         3'd1:    return 3'd0;
         3'd2:    return 3'd1;
         3'd3:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [2:0] code_to_rank(input logic [2:0] code);
      case (code)
         3'd3:    return 3'd0;
         3'd0:    return 3'd1;
         3'd2:    return 3'd3;
         3'd4:    return 3'd4;
         default: return 3'd2;
      endcase
   endfunction

   state_t            state_q, state_d;
   logic              phase_q, phase_d;
   logic              auto_q, auto_d;
   logic [2:0]        rank_q, rank_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        msel_q, msel_d;
   logic [2:0]        rr_sel_q, rr_sel_d;
   logic [1:0]        vr_sel_q, vr_sel_d;
   logic              acq_req_q, acq_req_d;
   logic [AMP_W-1:0]  amp_vx_q, amp_vx_d;
   logic [AMP_W-1:0]  amp_vr_q, amp_vr_d;
   logic [2:0]        range_q, range_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic go_apply;
   logic amp_lo, amp_hi;

   assign amp_lo = (amp_vr_q < RANGE_LO);
   assign amp_hi = (amp_vr_q > RANGE_HI);

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      auto_d    = auto_q;
      rank_d    = rank_q;
      steps_d   = steps_q;
      cnt_d     = cnt_q;
      msel_d    = msel_q;
      rr_sel_d  = rr_sel_q;
      vr_sel_d  = vr_sel_q;
      acq_req_d = 1'b0;
      amp_vx_d  = amp_vx_q;
      amp_vr_d  = amp_vr_q;
      range_d   = range_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      go_apply  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               auto_d   = i_auto_range;
               rank_d   = code_to_rank(i_Rr_init);
               vr_sel_d = i_Vr_Sel;
               phase_d  = 1'b0;
               steps_d  = '0;
               err_d    = 1'b0;
               busy_d   = 1'b1;
               go_apply = 1'b1;
            end
         end
         S_APPLY: begin
            cnt_d   = '0;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               state_d   = S_REQ;
               acq_req_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_REQ: state_d = S_WAIT;
         S_WAIT: begin
            if (i_acq_done) begin
               if (!phase_q) begin
                  amp_vx_d = i_acq_amp;
                  phase_d  = 1'b1;
                  go_apply = 1'b1;
               end else begin
                  amp_vr_d = i_acq_amp;
                  state_d  = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (auto_q && (amp_lo || amp_hi) && steps_q != STEP_MAX &&
                !(amp_lo && rank_q == 3'd4) && !(amp_hi && rank_q == 3'd0)) begin
               rank_d   = amp_lo ? rank_q + 3'd1 : rank_q - 3'd1;
               steps_d  = steps_q + 1'b1;
               phase_d  = 1'b0;
               go_apply = 1'b1;
            end else begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               range_d = rank_to_code(rank_q);
               err_d   = auto_q && (amp_lo || amp_hi);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            msel_d  = MSEL_GND;
         end
         default: state_d = S_IDLE;
      endcase

      if (go_apply) begin
         state_d  = S_APPLY;
         msel_d   = phase_d ? MSEL_VR : MSEL_VX;
         rr_sel_d = rank_to_code(rank_d);
      end

      // Abort discards whatever the current cycle would have latched or reported.
      if (i_abort && state_q != S_IDLE) begin
         state_d   = S_IDLE;
         msel_d    = MSEL_GND;
         busy_d    = 1'b0;
         acq_req_d = 1'b0;
         done_d    = 1'b0;
         amp_vx_d  = amp_vx_q;
         amp_vr_d  = amp_vr_q;
         range_d   = range_q;
         err_d     = err_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         phase_q   <= 1'b0;
         auto_q    <= 1'b0;
         rank_q    <= 3'd2;
         steps_q   <= '0;
         cnt_q     <= '0;
         msel_q    <= MSEL_GND;
         rr_sel_q  <= 3'd1;
         vr_sel_q  <= 2'd0;
         acq_req_q <= 1'b0;
         amp_vx_q  <= '0;
         amp_vr_q  <= '0;
         range_q   <= 3'd1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         auto_q    <= auto_d;
         rank_q    <= rank_d;
         steps_q   <= steps_d;
         cnt_q     <= cnt_d;
         msel_q    <= msel_d;
         rr_sel_q  <= rr_sel_d;
         vr_sel_q  <= vr_sel_d;
         acq_req_q <= acq_req_d;
         amp_vx_q  <= amp_vx_d;
         amp_vr_q  <= amp_vr_d;
         range_q   <= range_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign o_CTRL_Measure_Sel = msel_q;
   assign o_CTRL_Rr_Sel      = rr_sel_q;
   assign o_CTRL_Vr_Sel      = vr_sel_q;
   assign o_acq_req          = acq_req_q;
   assign o_amp_vx           = amp_vx_q;
   assign o_amp_vr           = amp_vr_q;
   assign o_range            = range_q;
   assign o_busy             = busy_q;
   assign o_done             = done_q;
   assign o_range_err        = err_q;

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Scoreboard bench for meas_seq_ctrl: runs push expected results, a monitor checks them on o_done.
module tb_meas_seq_ctrl;
   localparam int S = 100;

   typedef struct {
      logic [15:0] vx;
      logic [15:0] vr;
      logic [2:0]  rng;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        auto_r = 1'b0;
   logic [2:0]  rr_init = 3'd1;
   logic [1:0]  vr_in = 2'd0;
   logic        resp_done = 1'b0;
   logic [15:0] resp_amp = '0;
   logic        stray_done = 1'b0;
   logic [15:0] stray_amp = '0;

   logic [3:0]  msel;
   logic [2:0]  rr_sel;
   logic [1:0]  vr_sel;
   logic        acq_req;
   logic [15:0] amp_vx;
   logic [15:0] amp_vr;
   logic [2:0]  rng;
   logic        busy;
   logic        done;
   logic        range_err;

   exp_t        exp_q[$];
   exp_t        e;
   logic [15:0] amp_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   bit          hold_resp = 1'b0;

   int          cyc = 0;
   int          apply_cyc = 0;
   int          acq_cnt = 0;
   logic [3:0]  prev_msel = 4'd6;
   logic [31:0] msel_hist = '0;
   logic [31:0] rr_hist = '0;

   always #5 clk = ~clk;

   meas_seq_ctrl #(.SETTLE_CYCLES(S)) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_start            (start),
      .i_abort            (abort),
      .i_auto_range       (auto_r),
      .i_Rr_init          (rr_init),
      .i_Vr_Sel           (vr_in),
      .i_acq_done         (resp_done | stray_done),
      .i_acq_amp          (resp_done ? resp_amp : stray_amp),
      .o_CTRL_Measure_Sel (msel),
      .o_CTRL_Rr_Sel      (rr_sel),
      .o_CTRL_Vr_Sel      (vr_sel),
      .o_acq_req          (acq_req),
      .o_amp_vx           (amp_vx),
      .o_amp_vr           (amp_vr),
      .o_range            (rng),
      .o_busy             (busy),
      .o_done             (done),
      .o_range_err        (range_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
   endtask

   // Monitor: tracks control sequence, acquisition timing and pops the scoreboard on o_done.
   always @(negedge clk) begin
      cyc++;
      if (msel != prev_msel) begin
         if (prev_msel == 4'd6 && msel == 4'd0) begin
            msel_hist = 32'h60;
            rr_hist   = '0;
            acq_cnt   = 0;
         end else begin
            msel_hist = {msel_hist[27:0], msel};
         end
         if (msel != 4'd6) apply_cyc = cyc;
         prev_msel = msel;
      end
      if (acq_req) begin
         chk("acq_req_delay", cyc - apply_cyc, S + 1);
         rr_hist = {rr_hist[28:0], rr_sel};
         acq_cnt++;
      end
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", done, 0);
         end else begin
            e = exp_q.pop_front();
            chk("amp_vx", amp_vx, e.vx);
            chk("amp_vr", amp_vr, e.vr);
            chk("range", rng, e.rng);
            chk("range_err", range_err, e.err);
            chk("busy_at_done", busy, 0);
         end
      end
   end

   // Acquisition responder: answers each request two cycles later with the next queued amplitude.
   initial begin
      forever begin
         @(negedge clk);
         if (acq_req && !hold_resp) begin
            @(negedge clk);
            @(negedge clk);
            if (amp_q.size() > 0) resp_amp = amp_q.pop_front();
            else resp_amp = 16'hDEAD;
            resp_done = 1'b1;
            @(negedge clk);
            resp_done = 1'b0;
         end
      end
   end

   task automatic check_reset(input string nm);
      chk({nm, "_msel"}, msel, 6);
      chk({nm, "_rr_sel"}, rr_sel, 1);
      chk({nm, "_vr_sel"}, vr_sel, 0);
      chk({nm, "_acq_req"}, acq_req, 0);
      chk({nm, "_amp_vx"}, amp_vx, 0);
      chk({nm, "_amp_vr"}, amp_vr, 0);
      chk({nm, "_range"}, rng, 1);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_err"}, range_err, 0);
   endtask

   task automatic start_run(input logic [2:0] init, input bit au, input logic [1:0] vs);
      @(negedge clk);
      rr_init = init;
      auto_r  = au;
      vr_in   = vs;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk(nm, seen, 1);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic do_run(input string nm, input logic [2:0] init, input bit au,
                         input int n_acq, input logic [31:0] rrh);
      start_run(init, au, 2'd2);
      chk({nm, "_busy"}, busy, 1);
      chk({nm, "_msel_vx"}, msel, 0);
      chk({nm, "_err_clr"}, range_err, 0);
      wait_done({nm, "_done_seen"});
      chk({nm, "_n_acq"}, acq_cnt, n_acq);
      chk({nm, "_rr_seq"}, rr_hist, rrh);
      chk({nm, "_msel_idle"}, msel, 6);
   endtask

   initial begin
      bit saw;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Manual run
      amp_q.push_back(16'd1000); amp_q.push_back(16'd30000);
      exp_q.push_back('{16'd1000, 16'd30000, 3'd1, 1'b0});
      do_run("manual", 3'd1, 1'b0, 2, 32'({3'd1, 3'd1}));
      chk("manual_msel_seq", msel_hist, 32'h6016);
      chk("manual_vr_sel", vr_sel, 2);

      // Auto-range up one step
      amp_q.push_back(16'd500); amp_q.push_back(16'd2000);
      amp_q.push_back(16'd700); amp_q.push_back(16'd20000);
      exp_q.push_back('{16'd700, 16'd20000, 3'd2, 1'b0});
      do_run("auto_up", 3'd1, 1'b1, 4, 32'({3'd1, 3'd1, 3'd2, 3'd2}));

      // Exactly RANGE_LO is in window
      amp_q.push_back(16'd5); amp_q.push_back(16'd4096);
      exp_q.push_back('{16'd5, 16'd4096, 3'd1, 1'b0});
      do_run("lo_edge", 3'd1, 1'b1, 2, 32'({3'd1, 3'd1}));

      // Above RANGE_HI steps down; exactly RANGE_HI then stops
      amp_q.push_back(16'd1); amp_q.push_back(16'd60000);
      amp_q.push_back(16'd2); amp_q.push_back(16'd52000);
      exp_q.push_back('{16'd2, 16'd52000, 3'd1, 1'b0});
      do_run("hi_down", 3'd2, 1'b1, 4, 32'({3'd2, 3'd2, 3'd1, 3'd1}));

      // Too high at smallest Rr
      amp_q.push_back(16'd111); amp_q.push_back(16'd60000);
      exp_q.push_back('{16'd111, 16'd60000, 3'd3, 1'b1});
      do_run("down_limit", 3'd3, 1'b1, 2, 32'({3'd3, 3'd3}));

      // Abort during VR settle; init code 6 behaves as code 1
      amp_q.push_back(16'd1234);
      start_run(3'd6, 1'b0, 2'd1);
      chk("abort_err_clr", range_err, 0);
      chk("abort_rr_code6", rr_sel, 1);
      for (int i = 0; i < 1000 && msel != 4'd1; i++) @(negedge clk);
      chk("abort_reach_vr", msel, 1);
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_msel", msel, 6);
      chk("abort_busy", busy, 0);
      chk("abort_amp_vx", amp_vx, 1234);
      saw = 1'b0;
      repeat (250) begin
         @(negedge clk);
         if (done) saw = 1'b1;
      end
      chk("abort_no_done", saw, 0);
      stray_amp = 16'd7;
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      @(negedge clk);
      chk("stray_amp_vx", amp_vx, 1234);
      chk("stray_amp_vr", amp_vr, 60000);
      chk("stray_busy", busy, 0);

      amp_q.push_back(16'd10); amp_q.push_back(16'd20000);
      exp_q.push_back('{16'd10, 16'd20000, 3'd1, 1'b0});
      do_run("restart", 3'd1, 1'b0, 2, 32'({3'd1, 3'd1}));

      // MAX_STEPS limit walking all the way up
      for (int i = 0; i < 5; i++) begin
         amp_q.push_back(16'(20 + i));
         amp_q.push_back(16'd100);
      end
      exp_q.push_back('{16'd24, 16'd100, 3'd4, 1'b1});
      do_run("max_steps", 3'd3, 1'b1, 10,
             32'({3'd3, 3'd3, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd4, 3'd4}));

      // Asynchronous reset while waiting on an acquisition
      hold_resp = 1'b1;
      start_run(3'd2, 1'b0, 2'd3);
      for (int i = 0; i < 1000 && !acq_req; i++) @(negedge clk);
      chk("arst_reach_req", acq_req, 1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("arst");
      @(negedge clk);
      rst_n = 1'b1;
      hold_resp = 1'b0;

      amp_q.push_back(16'd55); amp_q.push_back(16'd40000);
      exp_q.push_back('{16'd55, 16'd40000, 3'd1, 1'b0});
      do_run("post_arst", 3'd1, 1'b0, 2, 32'({3'd1, 3'd1}));

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
      $fatal(1);
   end

endmodule
